// File: rtl/adc_fir_filter.sv
// Purpose : sequential single-multiplier FIR over 12-bit offset-binary ADC samples, rounded and saturated output.
// Latency : TAPS+1 clocks from the accepting edge to out_valid (17 at default).
// Backpr. : no stall; in_valid while busy drops the sample and pulses overrun.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (clears history, aborts any computation)
//   in_data    12-bit unsigned offset-binary sample
//   in_valid   one-cycle strobe, sample present
//   out_data   OUT_W signed filtered sample, held between out_valid pulses
//   out_valid  one-cycle strobe, out_data updated
//   busy       filter computing (MAC or ROUND), input not accepted
//   overrun    one-cycle pulse, a sample arrived while busy and was dropped
//   sat        one-cycle pulse with out_valid when the result was clipped
//
// COEFS is a packed array; COEFS[k] (slice k, counted from the LSB end)
// multiplies x[n-k].
module adc_fir_filter #(
    parameter int TAPS   = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 15,
    parameter int OUT_W  = 16,
    parameter logic [TAPS-1:0][COEF_W-1:0] COEFS = {TAPS{COEF_W'(2048)}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      in_data,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             sat
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int PROD_W = 12 + COEF_W;
    localparam int ACC_W  = 12 + COEF_W + PTR_W;

    // Rounding constant 2^(FRAC-1) and output clip limits, all at ACC_W+1 bits
    // so the rounding add cannot wrap.
    localparam logic signed [ACC_W:0] RND_C =
        {{(ACC_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ROUND
    } state_t;

    state_t                    state_q, state_d;
    logic signed [11:0]        hist_q [TAPS];
    logic        [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic        [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic        [PTR_W-1:0]   k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      sat_q, sat_d;
    logic                      hist_we;

    logic signed [11:0]        x_s;
    logic signed [PROD_W-1:0]  h_ext, c_ext, prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W:0]     rnd_sum, shifted;
    logic        [OUT_W-1:0]   sat_val;
    logic                      clip;

    // Offset binary to two's complement: flipping the MSB subtracts 2048.
    assign x_s = {~in_data[11], in_data[10:0]};

    // Datapath: one product per clock, plus the rounded/saturated view of the
    // accumulator including the current product, so the final MAC step can
    // load the output register directly.
    always_comb begin
        h_ext   = PROD_W'(hist_q[rd_ptr_q]);
        c_ext   = PROD_W'($signed(COEFS[k_q]));
        prod    = h_ext * c_ext;
        acc_sum = acc_q + ACC_W'(prod);
        rnd_sum = (ACC_W+1)'(acc_sum) + RND_C;
        shifted = rnd_sum >>> FRAC;
        clip    = 1'b0;
        sat_val = shifted[OUT_W-1:0];
        if (shifted > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_W-1:0];
            clip    = 1'b1;
        end else if (shifted < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        hist_we     = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sat_d       = 1'b0;
        overrun_d   = in_valid && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    hist_we  = 1'b1;
                    rd_ptr_d = wr_ptr_q;
                    k_d      = '0;
                    acc_d    = '0;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                // Walk backwards through history: newest sample pairs with COEFS[0].
                acc_d    = acc_sum;
                rd_ptr_d = rd_ptr_q - PTR_W'(1);
                k_d      = k_q + PTR_W'(1);
                if (k_q == PTR_W'(TAPS-1)) begin
                    out_data_d  = sat_val;
                    out_valid_d = 1'b1;
                    sat_d       = clip;
                    state_d     = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            sat_q       <= sat_d;
            if (hist_we) begin
                hist_q[wr_ptr_q] <= x_s;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign sat       = sat_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_fir_filter.sv
// Directed bench for adc_fir_filter: default-coefficient instance plus an
// instance with all coefficients at -1.0 to drive the output past full scale.
module tb_adc_fir_filter;

    logic        clk;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic [15:0] out_data;
    logic        out_valid, busy, overrun, sat;

    logic [11:0] s_in_data;
    logic        s_in_valid;
    logic [15:0] s_out_data;
    logic        s_out_valid, s_busy, s_overrun, s_sat;

    int n_checks = 0;
    int n_fail   = 0;

    int ov_pulses  = 0;
    int or_pulses  = 0;
    int sat_pulses = 0;
    int s_or_pulses = 0;

    adc_fir_filter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun),
        .sat      (sat)
    );

    adc_fir_filter #(
        .COEFS({16{16'sh8000}})
    ) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (s_in_data),
        .in_valid (s_in_valid),
        .out_data (s_out_data),
        .out_valid(s_out_valid),
        .busy     (s_busy),
        .overrun  (s_overrun),
        .sat      (s_sat)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Pulse counters, sampled well clear of both clock edges.
    always @(posedge clk) begin
        #2;
        if (out_valid) ov_pulses++;
        if (overrun) or_pulses++;
        if (sat) sat_pulses++;
        if (s_overrun) s_or_pulses++;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge following the accepting edge.
    task automatic send(input bit sel, input logic [11:0] d);
        @(negedge clk);
        if (sel) begin
            s_in_data  = d;
            s_in_valid = 1'b1;
        end else begin
            in_data  = d;
            in_valid = 1'b1;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        in_valid   = 1'b0;
    endtask

    // lat counts negedges after the accept; 17 means out_valid rose on the
    // 17th rising edge counting the accepting one. lat = 0 means timeout.
    task automatic get_out(input bit sel, output int val, output int satv, output int lat);
        val  = 0;
        satv = 0;
        lat  = 0;
        for (int i = 1; i <= 40; i++) begin
            if (sel ? s_out_valid : out_valid) begin
                lat  = i;
                val  = sel ? int'($signed(s_out_data)) : int'($signed(out_data));
                satv = sel ? int'(s_sat) : int'(sat);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic sample_and_check(input bit sel, input logic [11:0] d,
                                    input int exp_val, input int exp_sat, input string tag);
        int val, satv, lat;
        send(sel, d);
        get_out(sel, val, satv, lat);
        check({tag, "_lat"}, lat, 17);
        check({tag, "_val"}, val, exp_val);
        check({tag, "_sat"}, satv, exp_sat);
    endtask

    task automatic impulse_seq(input string tag);
        for (int n = 0; n < 18; n++) begin
            sample_and_check(1'b0, (n == 0) ? 12'd4095 : 12'd2048,
                             (n < 16) ? 128 : 0, 0, $sformatf("%s%0d", tag, n));
        end
    endtask

    initial begin
        int base_ov, base_or;
        // Step: 2047 * 2048 / 32768 = 127.9375 per tap, rounded half-up.
        int step_exp [20] = '{128, 256, 384, 512, 640, 768, 896, 1024,
                              1151, 1279, 1407, 1535, 1663, 1791, 1919, 2047,
                              2047, 2047, 2047, 2047};

        rst_n      = 1'b0;
        in_data    = 12'd0;
        in_valid   = 1'b0;
        s_in_data  = 12'd0;
        s_in_valid = 1'b0;

        // Reset state
        do_reset();
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_s_busy", int'(s_busy), 0);

        // Step response, samples 40 clocks apart
        for (int n = 0; n < 20; n++) begin
            sample_and_check(1'b0, 12'd4095, step_exp[n], 0, $sformatf("step%0d", n));
            repeat (22) @(negedge clk);
        end

        // Impulse response
        do_reset();
        impulse_seq("imp");

        // Negative full scale, back-to-back samples with no overrun
        do_reset();
        base_or = or_pulses;
        for (int n = 0; n < 18; n++) begin
            sample_and_check(1'b0, 12'd0, (n < 16) ? -128 * (n + 1) : -2048, 0,
                             $sformatf("neg%0d", n));
        end
        check("neg_out_hex", int'(out_data), 'hF800);
        check("neg_no_overrun", or_pulses - base_or, 0);

        // Overrun: extra strobe 5 clocks after an accepted sample
        do_reset();
        base_or = or_pulses;
        send(1'b0, 12'd4095);
        for (int i = 1; i <= 30; i++) begin
            if (i == 1) check("ovr_busy_mac", int'(busy), 1);
            if (i == 5) begin
                in_data  = 12'd0;
                in_valid = 1'b1;
            end
            if (i == 6) begin
                in_valid = 1'b0;
                check("ovr_pulse", int'(overrun), 1);
            end
            if (i == 7) check("ovr_single", int'(overrun), 0);
            if (i == 16) check("ovr_not_early", int'(out_valid), 0);
            if (i == 17) begin
                check("ovr_out_valid", int'(out_valid), 1);
                check("ovr_out_val", int'($signed(out_data)), 128);
                check("ovr_busy_round", int'(busy), 1);
            end
            if (i == 18) begin
                check("ovr_busy_idle", int'(busy), 0);
                check("ovr_valid_single", int'(out_valid), 0);
            end
            @(negedge clk);
        end
        check("ovr_pulse_count", or_pulses - base_or, 1);
        // Dropped -2048 would cancel the earlier 2047 here.
        sample_and_check(1'b0, 12'd2048, 128, 0, "ovr_after");

        // Reset mid-MAC aborts the sample and clears history
        do_reset();
        send(1'b0, 12'd4095);
        base_ov = ov_pulses;
        for (int i = 1; i <= 40; i++) begin
            if (i == 8) rst_n = 1'b0;
            if (i == 9) begin
                rst_n = 1'b1;
                check("mid_rst_busy", int'(busy), 0);
            end
            @(negedge clk);
        end
        check("mid_rst_no_valid", ov_pulses - base_ov, 0);
        impulse_seq("post_rst");

        // Saturation on the -1.0 coefficient instance with full negative input
        do_reset();
        for (int n = 0; n < 18; n++) begin
            sample_and_check(1'b1, 12'd0, (n < 15) ? 2048 * (n + 1) : 32767,
                             (n < 15) ? 0 : 1, $sformatf("satur%0d", n));
        end
        check("sat_out_hex", int'(s_out_data), 'h7FFF);
        check("sat_no_overrun", s_or_pulses, 0);

        check("main_sat_never", sat_pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
